// File: rtl/rv32_fetch_queue.sv
// rv32_fetch_queue: sequential instruction prefetch with an in-order word+PC FIFO.
// Optional feature macro: RV_FETCH_ALIGN_CHECK_EN (misaligned redirect raises a sticky fetch_fault).
module rv32_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            fetch_fault
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] word;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_n [DEPTH];
    entry_t          head_n;
    logic [PW-1:0]   rd_q, rd_n, wr_q, wr_n;
    logic [CW-1:0]   cnt_q, cnt_n, outst_q, outst_n, disc_q, disc_n;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_n, resp_pc_q, resp_pc_n;
    logic [XLEN-1:0] addr_n, start_pc, redir_pc;
    logic            req_n, fault_q, fault_n, valid_n;
    logic            push, pop, pending, misaligned;

`ifdef RV_FETCH_ALIGN_CHECK_EN
    assign misaligned  = (redirect_pc[1:0] != 2'b00);
    assign redir_pc    = redirect_pc;
    assign fetch_fault = fault_q;
`else
    assign misaligned  = 1'b0;
    assign redir_pc    = redirect_pc & ~XLEN'(3);
    assign fetch_fault = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            outst_q     <= '0;
            disc_q      <= '0;
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            fault_q     <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            mem_q       <= mem_n;
            rd_q        <= rd_n;
            wr_q        <= wr_n;
            cnt_q       <= cnt_n;
            outst_q     <= outst_n;
            disc_q      <= disc_n;
            fetch_pc_q  <= fetch_pc_n;
            resp_pc_q   <= resp_pc_n;
            fault_q     <= fault_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            instr_valid <= valid_n;
            instr       <= head_n.word;
            instr_pc    <= head_n.pc;
        end
    end

    // Next state: bus accounting, FIFO push/pop, redirect flush, next request
    always_comb begin
        mem_n      = mem_q;
        rd_n       = rd_q;
        wr_n       = wr_q;
        cnt_n      = cnt_q;
        outst_n    = outst_q;
        disc_n     = disc_q;
        fetch_pc_n = fetch_pc_q;
        resp_pc_n  = resp_pc_q;
        fault_n    = fault_q;
        req_n      = imem_req;
        addr_n     = imem_addr;
        start_pc   = fetch_pc_q;
        push       = 1'b0;
        pop        = instr_valid && instr_ready;
        pending    = imem_req && !imem_gnt;

        if (imem_req && imem_gnt) outst_n = outst_n + CW'(1);

        if (imem_rvalid) begin
            outst_n = outst_n - CW'(1);
            if (disc_q != '0) disc_n = disc_q - CW'(1);
            else if (!redirect) push = 1'b1;
        end

        if (pop) begin
            rd_n  = rd_q + PW'(1);
            cnt_n = cnt_n - CW'(1);
        end

        if (push) begin
            mem_n[wr_q] = '{word: imem_rdata, pc: resp_pc_q};
            wr_n        = wr_q + PW'(1);
            cnt_n       = cnt_n + CW'(1);
            resp_pc_n   = resp_pc_q + XLEN'(4);
        end

        // Flush: everything still in flight, including a held request, is dropped on return
        if (redirect) begin
            rd_n      = '0;
            wr_n      = '0;
            cnt_n     = '0;
            disc_n    = outst_n + CW'(pending);
            start_pc  = redir_pc;
            resp_pc_n = redir_pc;
            fault_n   = misaligned;
        end

        // A held request keeps its address; otherwise launch when a credit is free
        if (pending) begin
            fetch_pc_n = start_pc;
        end else if (!fault_n &&
                     ((CW+1)'(cnt_n) + (CW+1)'(outst_n) < (CW+1)'(DEPTH))) begin
            req_n      = 1'b1;
            addr_n     = start_pc;
            fetch_pc_n = start_pc + XLEN'(4);
        end else begin
            req_n      = 1'b0;
            fetch_pc_n = start_pc;
        end

        valid_n = (cnt_n != '0);
        head_n  = mem_n[rd_n];
    end

    // A response with nothing outstanding is a memory protocol violation
    assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (outst_q != '0));

endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Directed bench for rv32_fetch_queue with a variable-latency in-order memory returning addr as data.
module tb_rv32_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready, fetch_fault;
    logic [31:0] instr, instr_pc;

    int checks   = 0;
    int failures = 0;
    int lat      = 1;

    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];
    logic [31:0] req_log[$];
    logic        pv[8];
    logic [31:0] pd[8];

    rv32_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory: fixed-latency pipeline, response data equals the request address
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
        end else begin
            pv[0] <= imem_req && imem_gnt;
            pd[0] <= imem_addr;
            for (int i = 1; i < 8; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
        end
    end

    always_comb begin
        imem_rvalid = pv[lat-1];
        imem_rdata  = pd[lat-1];
    end

    // Observation log of consumed instructions and granted addresses
    always @(posedge clk) begin
        if (!rst) begin
            if (instr_valid && instr_ready) begin
                pop_pc.push_back(instr_pc);
                pop_ins.push_back(instr);
            end
            if (imem_req && imem_gnt) req_log.push_back(imem_addr);
        end
    end

    task automatic wait_pops(input int n, input string name);
        for (int i = 0; i < 60 && pop_pc.size() < n; i++) @(negedge clk);
        checks++;
        if (pop_pc.size() < n) begin
            failures++;
            $display("FAIL %s_timeout pops=%0d need=%0d", name, pop_pc.size(), n);
        end
    endtask

    task automatic check_pops(input int n, input logic [31:0] base, input string name);
        for (int i = 0; i < n && i < pop_pc.size(); i++) begin
            logic [31:0] exp;
            exp = base + 32'(4 * i);
            checks++;
            if (pop_pc[i] !== exp || pop_ins[i] !== exp) begin
                failures++;
                $display("FAIL %s[%0d] pc=%h instr=%h exp=%h", name, i, pop_pc[i], pop_ins[i], exp);
            end
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect = 1'b0;
        pop_pc.delete(); pop_ins.delete(); req_log.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b1; instr_ready = 1'b1; lat = 1;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL first_req req=%b addr=%h exp=1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream;
        int n0;
        wait_pops(8, "stream");
        check_pops(8, 32'h0, "stream");
        n0 = pop_pc.size();
        repeat (8) @(negedge clk);
        checks++;
        if (pop_pc.size() != n0 + 8) begin
            failures++; $display("FAIL throughput pops=%0d exp=%0d", pop_pc.size() - n0, 8);
        end
    endtask

    task automatic test_backpressure;
        instr_ready = 1'b0;
        do_redirect(32'h40);
        repeat (10) @(negedge clk);
        checks++;
        if (req_log.size() != 4) begin
            failures++; $display("FAIL bp_req_count got=%0d exp=4", req_log.size());
        end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            checks++;
            if (req_log[i] !== 32'h40 + 32'(4 * i)) begin
                failures++; $display("FAIL bp_req_addr[%0d] got=%h exp=%h", i, req_log[i], 32'h40 + 32'(4 * i));
            end
        end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_idle got=%b exp=0", imem_req); end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
            failures++; $display("FAIL bp_head valid=%b pc=%h exp=1/40", instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        wait_pops(8, "bp_resume");
        check_pops(8, 32'h40, "bp_resume");
    endtask

    task automatic test_same_cycle;
        logic [31:0] head;
        repeat (3) @(negedge clk);
        head = instr_pc;
        checks++;
        if (instr_valid !== 1'b1 || imem_rvalid !== 1'b1) begin
            failures++; $display("FAIL sc_setup valid=%b rvalid=%b exp=1/1", instr_valid, imem_rvalid);
        end
        pop_pc.delete(); pop_ins.delete();
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if (pop_pc.size() != 1 || pop_pc[0] !== head) begin
            failures++; $display("FAIL sc_head_pop n=%0d pc=%h exp=1/%h", pop_pc.size(), pop_pc[0], head);
        end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL sc_flush valid=%b exp=0", instr_valid); end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++; $display("FAIL sc_req req=%b addr=%h exp=1/200", imem_req, imem_addr);
        end
        pop_pc.delete(); pop_ins.delete();
        wait_pops(2, "sc_next");
        check_pops(2, 32'h200, "sc_next");
    endtask

    task automatic test_wrap;
        do_redirect(32'hFFFF_FFF8);
        wait_pops(4, "wrap");
        check_pops(4, 32'hFFFF_FFF8, "wrap");
        checks++;
        if (req_log.size() < 3 || req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0) begin
            failures++; $display("FAIL wrap_addr n=%0d a1=%h a2=%h exp=fffffffc/0", req_log.size(), req_log[1], req_log[2]);
        end
    endtask

    task automatic test_pending;
        logic [31:0] a;
        imem_gnt = 1'b0;
        @(negedge clk);
        a = imem_addr;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== a) begin
            failures++; $display("FAIL pend_hold req=%b addr=%h exp=1/%h", imem_req, imem_addr, a);
        end
        do_redirect(32'h300);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0) begin
            failures++; $display("FAIL pend_redirect req=%b addr=%h valid=%b exp=1/%h/0", imem_req, imem_addr, instr_valid, a);
        end
        repeat (2) @(negedge clk);
        imem_gnt = 1'b1;
        wait_pops(2, "pend");
        check_pops(2, 32'h300, "pend");
        checks++;
        if (req_log.size() < 2 || req_log[0] !== a || req_log[1] !== 32'h300) begin
            failures++; $display("FAIL pend_order n=%0d r0=%h r1=%h exp=%h/300", req_log.size(), req_log[0], req_log[1], a);
        end
    endtask

    task automatic test_align;
        do_redirect(32'h102);
`ifdef RV_FETCH_ALIGN_CHECK_EN
        checks++;
        if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL align_fault fault=%b req=%b valid=%b exp=1/0/0", fetch_fault, imem_req, instr_valid);
        end
        req_log.delete();
        repeat (6) @(negedge clk);
        checks++;
        if (req_log.size() != 0 || fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL align_stall reqs=%0d fault=%b valid=%b exp=0/1/0", req_log.size(), fetch_fault, instr_valid);
        end
        do_redirect(32'h200);
        checks++;
        if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++; $display("FAIL align_clear fault=%b req=%b addr=%h exp=0/1/200", fetch_fault, imem_req, imem_addr);
        end
        wait_pops(1, "align");
        check_pops(1, 32'h200, "align");
`else
        checks++;
        if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++; $display("FAIL align_force fault=%b req=%b addr=%h exp=0/1/100", fetch_fault, imem_req, imem_addr);
        end
        wait_pops(1, "align");
        check_pops(1, 32'h100, "align");
`endif
    endtask

    task automatic test_latency3;
        instr_ready = 1'b0;
        repeat (12) @(negedge clk);
        lat = 3;
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (dut.outst_q < 2) begin
            failures++; $display("FAIL lat3_setup outstanding=%0d exp>=2", dut.outst_q);
        end
        do_redirect(32'h100);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL lat3_flush valid=%b exp=0", instr_valid); end
        wait_pops(4, "lat3");
        check_pops(4, 32'h100, "lat3");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_same_cycle();
        test_wrap();
        test_pending();
        test_align();
        test_latency3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
